// File: rtl/lb2apb.sv
// Local-bus to APB bridge: one outstanding transfer, write wins over read,
// optional ACCESS-phase timeout reported through err.
module lb2apb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                wen,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                wready,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                ren,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic [DATA_W-1:0]  pwdata_d, rdata_d;
    logic [STRB_W-1:0]  pstrb_d;
    logic               wready_d, rvalid_d, err_d;
    logic               timeout_hit;

    // A timeout of zero leaves the transfer waiting on pready indefinitely
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1)) && !pready;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            wready  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            psel    <= psel_d;
            penable <= penable_d;
            pwrite  <= pwrite_d;
            paddr   <= paddr_d;
            pwdata  <= pwdata_d;
            pstrb   <= pstrb_d;
            rdata   <= rdata_d;
            rvalid  <= rvalid_d;
            wready  <= wready_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        psel_d    = psel;
        penable_d = penable;
        pwrite_d  = pwrite;
        paddr_d   = paddr;
        pwdata_d  = pwdata;
        pstrb_d   = pstrb;
        rdata_d   = rdata;
        rvalid_d  = 1'b0;
        wready_d  = 1'b0;
        err_d     = 1'b0;

        unique case (state)
            IDLE: begin
                // Write has priority; a held ren is picked up on a later IDLE cycle
                if (wen) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = waddr;
                    pwdata_d = wdata;
                    pstrb_d  = wstrb;
                end else if (ren) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    paddr_d  = raddr;
                    pwdata_d = '0;
                    pstrb_d  = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready || timeout_hit) begin
                    state_d   = DONE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    wready_d  = pwrite;
                    rvalid_d  = !pwrite;
                    err_d     = pready ? pslverr : 1'b1;
                    if (!pwrite) begin
                        rdata_d = pready ? prdata : '0;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
